// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode/funct constants, flag indices and writeback stage types
//
// Purpose: constants shared by the ALU and the writeback stage, plus the
// writeback FSM state, the write-data select type and the branch target helper.
package alu_pkg;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // Bit positions inside alu_flags
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 0;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } wb_state_t;

  // Source of register write data for non-memory instructions
  typedef enum logic [1:0] {
    WB_NONE     = 2'd0,
    WB_RESULT   = 2'd1,
    WB_FLAG_NEG = 2'd2
  } wb_sel_t;

  // pc + 4 + (sign_extend(imm) << 2), wrapping at 32 bits
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// rtl/alu_writeback_stage_if.sv - EX-to-writeback handshake bundle
//
// Purpose: carries the ALU's instruction, result, flags, pc and store data
// from EX into the writeback stage with a valid/ready handshake.
// Signals: in_valid (EX->WB), in_ready (WB->EX), instruction[31:0],
//          alu_result[31:0], alu_flags[2:0] (zero,neg,ovf), pc[31:0], rt_data[31:0].
// Modports: master = EX side, slave = writeback stage.
interface alu_writeback_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic [31:0] pc;
  logic [31:0] rt_data;

  modport master (
    output in_valid,
    output instruction,
    output alu_result,
    output alu_flags,
    output pc,
    output rt_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  instruction,
    input  alu_result,
    input  alu_flags,
    input  pc,
    input  rt_data,
    output in_ready
  );

endinterface

// File: rtl/wb_decode.sv
// rtl/wb_decode.sv - combinational instruction decode for the writeback stage
//
// Purpose: classifies an instruction for writeback.
// Ports: instruction[31:0] in; dest[4:0] (rd for R-type, rt otherwise),
//        wb_sel (write data source), is_branch, br_ne (branch on not-zero),
//        is_trap (signed add/sub that traps on overflow), is_load, is_store out.
import alu_pkg::*;

module wb_decode (
  input  logic [31:0] instruction,
  output logic [4:0]  dest,
  output wb_sel_t     wb_sel,
  output logic        is_branch,
  output logic        br_ne,
  output logic        is_trap,
  output logic        is_load,
  output logic        is_store
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  // rs and shamt have no bearing on writeback
  assign unused_fields = ^{instruction[25:21], instruction[10:6]};

  always_comb begin
    dest      = (opcode == OP_RTYPE) ? instruction[15:11] : instruction[20:16];
    wb_sel    = WB_NONE;
    is_branch = 1'b0;
    br_ne     = 1'b0;
    is_trap   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB: begin
            wb_sel  = WB_RESULT;
            is_trap = 1'b1;
          end
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLL, FN_SLLV, FN_SRL, FN_SRLV, FN_SRA, FN_SRAV:
            wb_sel = WB_RESULT;
          FN_SLT, FN_SLTU:
            wb_sel = WB_FLAG_NEG;
          default: ;
        endcase
      end
      OP_ADDI: begin
        wb_sel  = WB_RESULT;
        is_trap = 1'b1;
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: wb_sel = WB_RESULT;
      OP_SLTI, OP_SLTIU:                  wb_sel = WB_FLAG_NEG;
      OP_BEQ:  is_branch = 1'b1;
      OP_BNE: begin
        is_branch = 1'b1;
        br_ne     = 1'b1;
      end
      OP_LW:   is_load  = 1'b1;
      OP_SW:   is_store = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// rtl/alu_writeback_stage.sv - ALU result consumer: writeback, branch, overflow trap, lw/sw
//
// Purpose: registers one instruction per accept from EX and produces register
// writeback, branch redirect, overflow exception and data memory transactions.
// Ports: clk, rst_n (async active-low); ex (slave handshake bundle);
//        wb_en/wb_addr/wb_data (register write strobe); br_taken/br_target;
//        ovf_exc; mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata, mem_err.
// Parameter: MEM_TIMEOUT - MEM_WAIT cycles allowed before abort (>= 2).
import alu_pkg::*;

module alu_writeback_stage #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_writeback_stage_if.slave  ex,
  output logic                  wb_en,
  output logic [4:0]            wb_addr,
  output logic [31:0]           wb_data,
  output logic                  br_taken,
  output logic [31:0]           br_target,
  output logic                  ovf_exc,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_err
);

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  wb_state_t        state;
  wb_state_t        state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             pend_load;
  logic [4:0]       pend_dest;

  logic [4:0]  dec_dest;
  wb_sel_t     dec_wb_sel;
  logic        dec_is_branch;
  logic        dec_br_ne;
  logic        dec_is_trap;
  logic        dec_is_load;
  logic        dec_is_store;

  logic        in_ready;
  logic        accept;
  logic        mem_done;
  logic        mem_timeout;
  logic        trap_hit;
  logic        wb_now;
  logic [31:0] wb_value;

  wb_decode u_decode (
    .instruction (ex.instruction),
    .dest        (dec_dest),
    .wb_sel      (dec_wb_sel),
    .is_branch   (dec_is_branch),
    .br_ne       (dec_br_ne),
    .is_trap     (dec_is_trap),
    .is_load     (dec_is_load),
    .is_store    (dec_is_store)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (accept && (dec_is_load || dec_is_store)) state_next = ST_MEM_WAIT;
      ST_MEM_WAIT: if (mem_done || mem_timeout)                 state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs. An ack on the last permitted cycle wins over the timeout.
  always_comb begin
    in_ready    = (state == ST_IDLE);
    accept      = in_ready && ex.in_valid;
    mem_done    = (state == ST_MEM_WAIT) && mem_ack;
    mem_timeout = (state == ST_MEM_WAIT) && !mem_ack && (wait_cnt == CNT_LAST);
  end

  assign ex.in_ready = in_ready;

  // Write data selection and the write qualifier for non-memory instructions
  always_comb begin
    trap_hit = dec_is_trap && ex.alu_flags[FLAG_OVF];
    wb_now   = (dec_wb_sel != WB_NONE) && (dec_dest != 5'd0) && !trap_hit;
    case (dec_wb_sel)
      WB_FLAG_NEG: wb_value = {31'b0, ex.alu_flags[FLAG_NEG]};
      default:     wb_value = ex.alu_result;
    endcase
  end

  // Datapath: strobes default low every cycle so each pulse lasts exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en     <= 1'b0;
      wb_addr   <= 5'd0;
      wb_data   <= 32'd0;
      br_taken  <= 1'b0;
      br_target <= 32'd0;
      ovf_exc   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_err   <= 1'b0;
      wait_cnt  <= '0;
      pend_load <= 1'b0;
      pend_dest <= 5'd0;
    end else begin
      wb_en    <= 1'b0;
      br_taken <= 1'b0;
      ovf_exc  <= 1'b0;
      mem_err  <= 1'b0;

      if (accept) begin
        br_target <= branch_target(ex.pc, ex.instruction[15:0]);
        br_taken  <= dec_is_branch && (ex.alu_flags[FLAG_ZERO] ^ dec_br_ne);
        ovf_exc   <= trap_hit;
        pend_load <= dec_is_load;
        pend_dest <= dec_dest;
        if (wb_now) begin
          wb_en   <= 1'b1;
          wb_addr <= dec_dest;
          wb_data <= wb_value;
        end
        if (dec_is_load || dec_is_store) begin
          mem_req   <= 1'b1;
          mem_we    <= dec_is_store;
          mem_addr  <= ex.alu_result;
          mem_wdata <= dec_is_store ? ex.rt_data : 32'd0;
          wait_cnt  <= '0;
        end
      end

      if (mem_done) begin
        mem_req  <= 1'b0;
        wait_cnt <= '0;
        // Loads into r0 complete the bus cycle but never write
        if (pend_load && (pend_dest != 5'd0)) begin
          wb_en   <= 1'b1;
          wb_addr <= pend_dest;
          wb_data <= mem_rdata;
        end
      end else if (mem_timeout) begin
        mem_req  <= 1'b0;
        mem_err  <= 1'b1;
        wait_cnt <= '0;
      end else if (state == ST_MEM_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb/tb_alu_writeback_stage.sv - self-checking bench for alu_writeback_stage
module tb_alu_writeback_stage;

  localparam int MEM_TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ovf_exc;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int vectors;
  int miscompares;

  alu_writeback_stage_if ex_if ();

  alu_writeback_stage #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex        (ex_if.slave),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .br_taken  (br_taken),
    .br_target (br_target),
    .ovf_exc   (ovf_exc),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        br;
    logic [31:0] tgt;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] res;
    logic [2:0]  flags;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        br;
    logic        chk_tgt;
    logic [31:0] tgt;
    logic        ovf;
  } dvec_t;

  function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, 5'd1, 5'd2, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  // Reference model: instruction classes taken from the opcode/funct tables,
  // branch target from signed arithmetic on the immediate.
  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] res,
                                 input logic [2:0] flags, input logic [31:0] pc);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] dest;
    int kind; // 0 none, 1 result, 2 negative flag, 3 trapping result
    logic signed [31:0] simm;
    op   = instr[31:26];
    fn   = instr[5:0];
    dest = (op == 6'd0) ? instr[15:11] : instr[20:16];
    simm = 32'($signed(instr[15:0]));
    kind = 0;
    e    = '0;
    if (op == 6'd0) begin
      if (fn inside {6'h20, 6'h22}) kind = 3;
      else if (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) kind = 1;
      else if (fn inside {6'h2A, 6'h2B}) kind = 2;
    end else if (op == 6'h08) kind = 3;
    else if (op inside {6'h09, 6'h0C, 6'h0D, 6'h0E}) kind = 1;
    else if (op inside {6'h0A, 6'h0B}) kind = 2;
    e.ovf     = (kind == 3) && flags[0];
    e.wb_en   = (kind != 0) && (dest != 5'd0) && !e.ovf;
    e.wb_addr = dest;
    e.wb_data = (kind == 2) ? {31'd0, flags[1]} : res;
    e.br      = (op == 6'h04 && flags[2]) || (op == 6'h05 && !flags[2]);
    e.tgt     = pc + 32'd4 + simm * 4;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] res,
                       input logic [2:0] flags, input logic [31:0] pc, input logic [31:0] rt);
    ex_if.in_valid    = v;
    ex_if.instruction = instr;
    ex_if.alu_result  = res;
    ex_if.alu_flags   = flags;
    ex_if.pc          = pc;
    ex_if.rt_data     = rt;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0);
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({wb_en, wb_addr, wb_data, br_taken, br_target, ovf_exc, mem_req, mem_we,
         mem_addr, mem_wdata, mem_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: some output nonzero wb_en=%b wb_addr=%0d br=%b ovf=%b mem_req=%b mem_err=%b, required all 0",
               wb_en, wb_addr, br_taken, ovf_exc, mem_req, mem_err);
    end
    vectors++;
    if (ex_if.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b required 1", ex_if.in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    dvec_t v[12];
    v[0]  = '{r_type(5'd3, 6'h20), 32'h8000_0000, 3'b001, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1};
    v[1]  = '{r_type(5'd3, 6'h21), 32'h8000_0000, 3'b001, 32'd0, 1'b1, 5'd3, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 1'b0};
    v[2]  = '{r_type(5'd5, 6'h2A), 32'hFFFF_FFFF, 3'b010, 32'd0, 1'b1, 5'd5, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0};
    v[3]  = '{i_type(6'h0B, 5'd6, 16'h0010), 32'h0000_1234, 3'b000, 32'd0, 1'b1, 5'd6, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0};
    v[4]  = '{r_type(5'd0, 6'h2A), 32'h0000_0001, 3'b010, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0};
    v[5]  = '{i_type(6'h04, 5'd2, 16'hFFFF), 32'd0, 3'b100, 32'h100, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'h100, 1'b0};
    v[6]  = '{i_type(6'h05, 5'd2, 16'hFFFF), 32'd0, 3'b100, 32'h100, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 32'h100, 1'b0};
    v[7]  = '{i_type(6'h05, 5'd2, 16'h0003), 32'd5, 3'b000, 32'hFFFF_FFF0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'h0000_0000, 1'b0};
    v[8]  = '{r_type(5'd9, 6'h22), 32'h7FFF_FFFF, 3'b001, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1};
    v[9]  = '{r_type(5'd9, 6'h23), 32'h7FFF_FFFF, 3'b001, 32'd0, 1'b1, 5'd9, 32'h7FFF_FFFF, 1'b0, 1'b0, 32'd0, 1'b0};
    v[10] = '{i_type(6'h08, 5'd4, 16'h0001), 32'h8000_0000, 3'b011, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1};
    v[11] = '{i_type(6'h0F, 5'd4, 16'h1234), 32'h1234_0000, 3'b000, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, v[i].instr, v[i].res, v[i].flags, v[i].pc, 32'd0);
      @(negedge clk);
      drive(1'b0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0);
      vectors++;
      if ({wb_en, br_taken, ovf_exc} !== {v[i].wb_en, v[i].br, v[i].ovf}) begin
        miscompares++;
        $display("FAIL directed[%0d] strobes: wb_en/br/ovf got %b%b%b required %b%b%b",
                 i, wb_en, br_taken, ovf_exc, v[i].wb_en, v[i].br, v[i].ovf);
      end
      if (v[i].wb_en) begin
        vectors++;
        if ({wb_addr, wb_data} !== {v[i].wb_addr, v[i].wb_data}) begin
          miscompares++;
          $display("FAIL directed[%0d] wb: got addr %0d data %h required addr %0d data %h",
                   i, wb_addr, wb_data, v[i].wb_addr, v[i].wb_data);
        end
      end
      if (v[i].chk_tgt) begin
        vectors++;
        if (br_target !== v[i].tgt) begin
          miscompares++;
          $display("FAIL directed[%0d] br_target: got %h required %h", i, br_target, v[i].tgt);
        end
      end
      @(negedge clk);
      vectors++;
      if ({wb_en, br_taken, ovf_exc} !== 3'b000) begin
        miscompares++;
        $display("FAIL directed[%0d] one_cycle: wb_en/br/ovf got %b%b%b required 000",
                 i, wb_en, br_taken, ovf_exc);
      end
    end
  endtask

  task automatic test_random_alu(input int n);
    logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h04, 6'h05, 6'h08,
                             6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    logic [5:0] fns [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h03, 6'h07, 6'h3F};
    logic [31:0] instr;
    logic [31:0] res;
    logic [31:0] pc;
    logic [2:0]  flags;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      instr = $urandom;
      instr[31:26] = ops[$urandom_range(0, 13)];
      if (instr[31:26] == 6'h00) instr[5:0] = fns[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) begin
        instr[20:16] = 5'd0;
        instr[15:11] = 5'd0;
      end
      res   = $urandom;
      pc    = $urandom;
      flags = 3'($urandom);
      e = model(instr, res, flags, pc);
      drive(1'b1, instr, res, flags, pc, $urandom);
      @(negedge clk);
      vectors++;
      if ({wb_en, br_taken, ovf_exc, br_target, mem_req, ex_if.in_ready} !==
          {e.wb_en, e.br, e.ovf, e.tgt, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL random[%0d] instr %h flags %b: wb_en/br/ovf %b%b%b tgt %h req %b rdy %b required %b%b%b tgt %h req 0 rdy 1",
                 i, instr, flags, wb_en, br_taken, ovf_exc, br_target, mem_req, ex_if.in_ready,
                 e.wb_en, e.br, e.ovf, e.tgt);
      end
      if (e.wb_en) begin
        vectors++;
        if ({wb_addr, wb_data} !== {e.wb_addr, e.wb_data}) begin
          miscompares++;
          $display("FAIL random[%0d] wb: got addr %0d data %h required addr %0d data %h",
                   i, wb_addr, wb_data, e.wb_addr, e.wb_data);
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        drive(1'b0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        vectors++;
        if ({wb_en, br_taken, ovf_exc} !== 3'b000) begin
          miscompares++;
          $display("FAIL random[%0d] idle: wb_en/br/ovf got %b%b%b required 000",
                   i, wb_en, br_taken, ovf_exc);
        end
      end
    end
    drive(1'b0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
  endtask

  // One lw/sw transaction; ack_at = MEM_WAIT cycle (1-based) that sees mem_ack, 0 = never
  task automatic mem_txn(input logic is_load, input logic [4:0] rt, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at);
    int  last;
    logic exp_wb;
    last = (ack_at == 0) ? MEM_TIMEOUT : ack_at;
    drive(1'b1, {(is_load ? 6'h23 : 6'h2B), 5'd3, rt, 16'($urandom)}, addr, 3'($urandom), 32'($urandom), wdata);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0);
    for (int c = 1; c <= last; c++) begin
      if (c > 1) @(negedge clk);
      vectors++;
      if ({mem_req, ex_if.in_ready, mem_we, mem_addr, mem_err, wb_en} !==
          {1'b1, 1'b0, !is_load, addr, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL mem_wait cycle %0d: req/rdy/we %b%b%b addr %h err %b wb %b required 101/%b addr %h err 0 wb 0",
                 c, mem_req, ex_if.in_ready, mem_we, mem_addr, mem_err, wb_en, !is_load, addr);
      end
      if (!is_load) begin
        vectors++;
        if (mem_wdata !== wdata) begin
          miscompares++;
          $display("FAIL mem_wdata cycle %0d: got %h required %h", c, mem_wdata, wdata);
        end
      end
      if (c == ack_at) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    exp_wb = is_load && (ack_at != 0) && (rt != 5'd0);
    vectors++;
    if ({mem_req, ex_if.in_ready, mem_err, wb_en} !== {1'b0, 1'b1, (ack_at == 0), exp_wb}) begin
      miscompares++;
      $display("FAIL mem_end ack_at %0d: req/rdy/err/wb %b%b%b%b required 01%b%b",
               ack_at, mem_req, ex_if.in_ready, mem_err, wb_en, (ack_at == 0), exp_wb);
    end
    if (exp_wb) begin
      vectors++;
      if ({wb_addr, wb_data} !== {rt, rdata}) begin
        miscompares++;
        $display("FAIL mem_load_wb: got addr %0d data %h required addr %0d data %h", wb_addr, wb_data, rt, rdata);
      end
    end
    @(negedge clk);
    vectors++;
    if ({wb_en, mem_err, mem_req} !== 3'b000) begin
      miscompares++;
      $display("FAIL mem_after: wb/err/req got %b%b%b required 000", wb_en, mem_err, mem_req);
    end
  endtask

  task automatic test_load_store;
    mem_txn(1'b1, 5'd7, 32'h40, 32'd0, 32'hDEAD_BEEF, 3);
    mem_txn(1'b0, 5'd8, 32'h1000, 32'hCAFE_F00D, 32'd0, 0);
    mem_txn(1'b0, 5'd8, 32'h2000, 32'h1234_5678, 32'd0, MEM_TIMEOUT);
    mem_txn(1'b1, 5'd9, 32'h3000, 32'd0, 32'h0BAD_CAFE, MEM_TIMEOUT);
    mem_txn(1'b1, 5'd11, 32'h3004, 32'd0, 32'h5555_AAAA, 0);
    mem_txn(1'b1, 5'd0, 32'h3008, 32'd0, 32'h7777_7777, 1);
  endtask

  task automatic test_random_mem(input int n);
    for (int i = 0; i < n; i++) begin
      mem_txn(1'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
              $urandom_range(0, MEM_TIMEOUT));
    end
  endtask

  task automatic test_ack_outside;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    vectors++;
    if ({wb_en, mem_err, mem_req, ex_if.in_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL ack_outside: wb/err/req/rdy got %b%b%b%b required 0001",
               wb_en, mem_err, mem_req, ex_if.in_ready);
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, {6'h23, 5'd3, 5'd7, 16'd0}, 32'h80, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid pre: mem_req got %b required 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_req, ex_if.in_ready, wb_en} !== 3'b010) begin
      miscompares++;
      $display("FAIL reset_mid async: req/rdy/wb got %b%b%b required 010", mem_req, ex_if.in_ready, wb_en);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h1111_2222;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({wb_en, mem_req, mem_err, ex_if.in_ready} !== 4'b0001) begin
        miscompares++;
        $display("FAIL reset_mid after[%0d]: wb/req/err/rdy got %b%b%b%b required 0001",
                 c, wb_en, mem_req, mem_err, ex_if.in_ready);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset;
    test_directed;
    test_random_alu(60);
    test_load_store;
    test_random_mem(10);
    test_ack_outside;
    test_random_alu(20);
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
